multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Multicycle sequencer for the MIPS-subset execution datapath.
- Replaces single-cycle decode with an FSM, so one shared instruction/data memory port serves fetch and load/store.
- Emits per-cycle datapath enables/selects, handles a variable-latency memory handshake, and counts retired instructions.
- Supported: LW, SW, J, JAL, JR, BEQ, BNE, ADDI, XORI, ADD, SUB, SLT.

Parameters:
TIMEOUT, 255, max cycles mem_req may wait for mem_ready before fault.
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous active-low reset (0 = reset)
opcode  input  6  IR[31:26]; valid from DECODE onward
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag, EXEC cycle
mem_ready  input  1  memory completes access this cycle
mem_req  output  1  memory access request
mem_we  output  1  memory write (with mem_req)
iord  output  1  address select: 0=PC, 1=ALU result register
ir_we  output  1  IR load
pc_we  output  1  PC load
pc_sel  output  2  0=PC+4, 1=branch target, 2=jump target, 3=rs
reg_we  output  1  regfile write
reg_dst  output  2  0=rt, 1=rd, 2=$31
wb_sel  output  2  0=ALU result, 1=memory data, 2=PC (already +4)
alu_op  output  3  000 ADD, 001 SUB, 010 XOR, 011 SLT
alu_src_b  output  2  0=rt, 1=sign-ext imm, 2=zero-ext imm
state  output  3  current state, debug
fault  output  1  sticky: illegal instruction or memory timeout
retired  output  CNT_W  instructions completed since reset

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- Outputs decode combinationally from state, opcode/funct, zero and mem_ready.
- Unlisted outputs are 0 in every state.
- Reset (reset=0 at a rising edge): state=FETCH, fault=0, retired=0, wait counter=0.
- While reset is low, all enables (mem_req, mem_we, ir_we, pc_we, reg_we) are forced 0.
- Reset mid-access aborts the access; nothing is written.
- FETCH: mem_req=1, iord=0.
  - If mem_ready: ir_we=1, pc_we=1, pc_sel=0, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - J: pc_we=1, pc_sel=2, retire, go to FETCH.
  - JAL: as J, plus reg_we=1, reg_dst=2, wb_sel=2.
  - R-type with funct 001000 (JR): pc_we=1, pc_sel=3, retire, go to FETCH.
  - Illegal opcode or R-type funct not in {100000, 100010, 101010, 001000}: fault=1, go to HALT.
  - All other instructions: go to EXEC.
- EXEC:
  - BEQ/BNE: alu_op=SUB, alu_src_b=0, pc_sel=1, pc_we=zero (BEQ) or !zero (BNE), retire, go to FETCH.
  - LW/SW: alu_op=ADD, alu_src_b=1, go to MEM.
  - ADDI: ADD with src 1. XORI: XOR with src 2. Both go to WB.
  - R-type: alu_op from funct (ADD/SUB/SLT), src 0, go to WB.
- MEM: mem_req=1, iord=1, mem_we=1 for SW.
  - On mem_ready: SW retires and goes to FETCH; LW goes to WB.
  - mem_we is held for the whole request; memory commits the write only on the mem_ready cycle.
- WB: reg_we=1, retire, go to FETCH.
  - R-type: reg_dst=1, wb_sel=0.
  - ADDI/XORI: reg_dst=0, wb_sel=0.
  - LW: reg_dst=0, wb_sel=1.
- HALT: all enables 0, fault=1. Left only by reset.
- Retire: retired increments by 1 on the clock edge that leaves the final state of an instruction. Wraps modulo 2^CNT_W.
- Latency with zero-wait memory (mem_ready=1 in the first request cycle):
  - J/JAL/JR: 2 cycles.
  - BEQ/BNE: 3 cycles.
  - R/ADDI/XORI/SW: 4 cycles.
  - LW: 5 cycles.
  - Each wait cycle adds 1.
- Timeout: the wait counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 && !mem_ready.
  - When the counter reaches TIMEOUT with mem_ready still low: fault=1, go to HALT, no enables asserted.
  - If mem_ready arrives in the same cycle the limit is reached, mem_ready wins.

Test Plan:
- Reset low 2 cycles, then high, mem_ready=1, ADD (opcode 0, funct 100000) -> state 0,1,2,4,0; reg_we=1 with reg_dst=1 only in WB; retired=1 after 4 cycles.
- LW (100011) with mem_ready low 3 cycles in MEM -> MEM held 4 cycles with iord=1, mem_we=0; WB wb_sel=1; retired increments after 8 cycles total.
- BEQ with zero=1 then BNE with zero=1 -> BEQ: pc_we=1, pc_sel=1 in EXEC; BNE: pc_we=0; each takes 3 cycles.
- JAL (000011) -> DECODE asserts pc_we, pc_sel=2, reg_we, reg_dst=2, wb_sel=2; back in FETCH next cycle; retired+1.
- Opcode 111111 -> fault=1, state=7 permanently, all enables 0; reset low for 1 cycle -> state=0, fault=0, retired=0.
- TIMEOUT=4, mem_ready held 0 in FETCH -> HALT entered after 4 request cycles, fault=1, ir_we never asserted.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle sequencer for the MIPS-subset datapath: one shared memory port for fetch and load/store,
// per-cycle datapath controls, memory wait-timeout fault and a retired-instruction counter.
module multicycle_control #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_sel,
    output logic [2:0]       alu_op,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       state,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    state_t              state_reg, state_next;
    logic [WAIT_W-1:0]   wait_reg, wait_next;
    logic                fault_reg;
    logic [CNT_W-1:0]    retired_reg;

    logic req_raw, we_raw, ir_raw, pc_raw, reg_raw;
    logic retire, fault_set, timeout_hit;

    // Limit is reached on the cycle whose unanswered request would push the count to TIMEOUT.
    assign timeout_hit = (wait_reg == WAIT_W'(TIMEOUT - 1));

    always_comb begin
        state_next = state_reg;
        req_raw    = 1'b0;
        we_raw     = 1'b0;
        ir_raw     = 1'b0;
        pc_raw     = 1'b0;
        reg_raw    = 1'b0;
        iord       = 1'b0;
        pc_sel     = 2'd0;
        reg_dst    = 2'd0;
        wb_sel     = 2'd0;
        alu_op     = ALU_ADD;
        alu_src_b  = 2'd0;
        retire     = 1'b0;
        fault_set  = 1'b0;

        case (state_reg)
            S_FETCH: begin
                req_raw = 1'b1;
                if (mem_ready) begin
                    ir_raw     = 1'b1;
                    pc_raw     = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    fault_set  = 1'b1;
                    state_next = S_HALT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_J: begin
                        pc_raw     = 1'b1;
                        pc_sel     = 2'd2;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_JAL: begin
                        pc_raw     = 1'b1;
                        pc_sel     = 2'd2;
                        reg_raw    = 1'b1;
                        reg_dst    = 2'd2;
                        wb_sel     = 2'd2;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_RTYPE: begin
                        case (funct)
                            FN_JR: begin
                                pc_raw     = 1'b1;
                                pc_sel     = 2'd3;
                                retire     = 1'b1;
                                state_next = S_FETCH;
                            end
                            FN_ADD, FN_SUB, FN_SLT: state_next = S_EXEC;
                            default: begin
                                fault_set  = 1'b1;
                                state_next = S_HALT;
                            end
                        endcase
                    end
                    OP_BEQ, OP_BNE, OP_ADDI, OP_XORI, OP_LW, OP_SW: state_next = S_EXEC;
                    default: begin
                        fault_set  = 1'b1;
                        state_next = S_HALT;
                    end
                endcase
            end
            S_EXEC: begin
                case (opcode)
                    OP_BEQ, OP_BNE: begin
                        alu_op     = ALU_SUB;
                        pc_sel     = 2'd1;
                        pc_raw     = (opcode == OP_BEQ) ? zero : !zero;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_b  = 2'd1;
                        state_next = S_MEM;
                    end
                    OP_ADDI: begin
                        alu_src_b  = 2'd1;
                        state_next = S_WB;
                    end
                    OP_XORI: begin
                        alu_op     = ALU_XOR;
                        alu_src_b  = 2'd2;
                        state_next = S_WB;
                    end
                    OP_RTYPE: begin
                        if (funct == FN_SUB)
                            alu_op = ALU_SUB;
                        else if (funct == FN_SLT)
                            alu_op = ALU_SLT;
                        state_next = S_WB;
                    end
                    default: begin
                        // IR changed under us; treat as illegal rather than guess.
                        fault_set  = 1'b1;
                        state_next = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                req_raw = 1'b1;
                iord    = 1'b1;
                we_raw  = (opcode == OP_SW);
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (timeout_hit) begin
                    fault_set  = 1'b1;
                    state_next = S_HALT;
                end
            end
            S_WB: begin
                reg_raw    = 1'b1;
                reg_dst    = (opcode == OP_RTYPE) ? 2'd1 : 2'd0;
                wb_sel     = (opcode == OP_LW) ? 2'd1 : 2'd0;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: state_next = S_HALT;
            default: begin
                fault_set  = 1'b1;
                state_next = S_HALT;
            end
        endcase
    end

    always_comb begin
        wait_next = wait_reg;
        if ((state_next != state_reg) && ((state_next == S_FETCH) || (state_next == S_MEM)))
            wait_next = '0;
        else if (req_raw && !mem_ready)
            wait_next = wait_reg + WAIT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= S_FETCH;
            wait_reg    <= '0;
            fault_reg   <= 1'b0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            if (fault_set)
                fault_reg <= 1'b1;
            if (retire)
                retired_reg <= retired_reg + CNT_W'(1);
        end
    end

    // Enables are gated by reset so an access in flight is abandoned without side effects.
    assign mem_req = reset & req_raw;
    assign mem_we  = reset & we_raw;
    assign ir_we   = reset & ir_raw;
    assign pc_we   = reset & pc_raw;
    assign reg_we  = reset & reg_raw;
    assign fault   = fault_reg | (reset & fault_set);
    assign state   = state_reg;
    assign retired = retired_reg;

endmodule
